// File: rtl/pipe_ctrl.sv
// pipe_ctrl - pipeline control unit for the five-stage RV64 core.
//
// It sequences the IF/ID/EX/MEM/WB pipeline registers around the EX stage.
// It produces the per-stage stall/flush enables and the PC redirect. It also
// inserts load-use bubbles and holds the pipe during multi-cycle EX ops and
// dcache misses. A saturating watchdog runs during every wait state.
//
// Parameters:
//   TIMEOUT_W           width of the wait-state watchdog counter
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_rs*_addr_i/read_i  source registers of the ID instruction
//   ex_rd_addr_i, ex_wreg_i, ex_is_load_i  destination of the EX instruction
//   ex_branch_flag_i, ex_pc_new_i          taken branch/jump and target
//   ex_mc_req_i, ex_mc_done_i              multi-cycle op request / result valid
//   mem_req_i, mem_ack_i                   dcache access / data valid
//   stall_o, flush_o    per-stage hold / bubble enables
//                       (bit 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB)
//   pc_redirect_o, pc_redirect_addr_o      redirect request and target
//   mc_start_o          start pulse to the multi-cycle unit
//   timeout_o           sticky watchdog error
//
// Optional feature macro: PIPE_CTRL_PERF_EN adds perf_stall_cyc_o and
// perf_redirect_o, which are 32-bit counters of stalled and redirect cycles.
//
// state    | meaning
// ---------+--------------------------------------------------
// RUN      | normal issue; hazards resolved combinationally
// MEM_WAIT | dcache miss outstanding, pipe held up to EX/MEM
// MC_WAIT  | multi-cycle EX op in flight, pipe held up to ID/EX

module pipe_ctrl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_read_i,
  input  logic        id_rs2_read_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_wreg_i,
  input  logic        ex_is_load_i,
  input  logic        ex_branch_flag_i,
  input  logic [63:0] ex_pc_new_i,
  input  logic        ex_mc_req_i,
  input  logic        ex_mc_done_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic        pc_redirect_o,
  output logic [63:0] pc_redirect_addr_o,
  output logic        mc_start_o,
  output logic        timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc_o,
  output logic [31:0] perf_redirect_o
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MC_WAIT} state_t;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 timeout_q;
  logic                 load_use;
  logic                 issue_rules;
  logic                 unused_pc_lsb;

  assign load_use = ex_is_load_i && ex_wreg_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_read_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_read_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // Targets are halfword aligned; bit 0 is always cleared.
  assign pc_redirect_addr_o = {ex_pc_new_i[63:1], 1'b0};
  assign unused_pc_lsb      = ex_pc_new_i[0];
  assign timeout_o          = timeout_q;

  always_comb begin
    stall_o       = 5'b00000;
    flush_o       = 5'b00000;
    pc_redirect_o = 1'b0;
    mc_start_o    = 1'b0;
    state_d       = state_q;
    issue_rules   = 1'b0;

    if (rst) begin
      flush_o = 5'b11111;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_req_i && !mem_ack_i) begin
            stall_o = 5'b01111;
            flush_o = 5'b10000;
            state_d = MEM_WAIT;
          end else begin
            issue_rules = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ack_i) begin
            stall_o = 5'b01111;
            flush_o = 5'b10000;
          end else begin
            issue_rules = 1'b1;
          end
        end
        MC_WAIT: begin
          // MEM holds a bubble here, so mem_req_i cannot be a real access.
          if (!ex_mc_done_i) begin
            stall_o = 5'b00111;
            flush_o = 5'b01000;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase

      // Shared by RUN without a miss and by the MEM_WAIT ack cycle.
      if (issue_rules) begin
        state_d = RUN;
        if (ex_mc_req_i && !ex_mc_done_i) begin
          stall_o    = 5'b00111;
          flush_o    = 5'b01000;
          mc_start_o = 1'b1;
          state_d    = MC_WAIT;
        end else if (ex_branch_flag_i) begin
          // The ID instruction is wrong-path, so load-use does not matter.
          pc_redirect_o = 1'b1;
          flush_o       = 5'b00110;
        end else if (load_use) begin
          stall_o = 5'b00011;
          flush_o = 5'b00100;
        end
      end
    end
  end

  always_comb begin
    if (state_d == RUN) begin
      wd_d = '0;
    end else if (wd_q != '1) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (wd_d == '1) begin
        timeout_q <= 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_redir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_redir_q <= 32'd0;
    end else begin
      if (stall_o != 5'b00000) perf_stall_q <= perf_stall_q + 32'd1;
      if (pc_redirect_o)       perf_redir_q <= perf_redir_q + 32'd1;
    end
  end

  assign perf_stall_cyc_o = perf_stall_q;
  assign perf_redirect_o  = perf_redir_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with explicit
// expected values, plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;

  localparam int TW   = 4;
  localparam int MAXC = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1_addr_i = '0, id_rs2_addr_i = '0;
  logic        id_rs1_read_i = 1'b0, id_rs2_read_i = 1'b0;
  logic [4:0]  ex_rd_addr_i = '0;
  logic        ex_wreg_i = 1'b0, ex_is_load_i = 1'b0;
  logic        ex_branch_flag_i = 1'b0;
  logic [63:0] ex_pc_new_i = '0;
  logic        ex_mc_req_i = 1'b0, ex_mc_done_i = 1'b0;
  logic        mem_req_i = 1'b0, mem_ack_i = 1'b0;
  logic [4:0]  stall_o, flush_o;
  logic        pc_redirect_o, mc_start_o, timeout_o;
  logic [63:0] pc_redirect_addr_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: what the pipe is waiting for, and the watchdog.
  bit m_wait_mem, m_wait_mc, m_to;
  int m_cnt;

  logic [11:0] got, exp_v;

  pipe_ctrl #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_read_i(id_rs1_read_i), .id_rs2_read_i(id_rs2_read_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_wreg_i(ex_wreg_i), .ex_is_load_i(ex_is_load_i),
    .ex_branch_flag_i(ex_branch_flag_i), .ex_pc_new_i(ex_pc_new_i),
    .ex_mc_req_i(ex_mc_req_i), .ex_mc_done_i(ex_mc_done_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .flush_o(flush_o),
    .pc_redirect_o(pc_redirect_o), .pc_redirect_addr_o(pc_redirect_addr_o),
    .mc_start_o(mc_start_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic drive_ctl(input bit mreq, input bit mack, input bit mcr,
                           input bit mcd, input bit br);
    mem_req_i = mreq; mem_ack_i = mack;
    ex_mc_req_i = mcr; ex_mc_done_i = mcd; ex_branch_flag_i = br;
  endtask

  task automatic set_lu(input bit ld, input bit wr, input logic [4:0] rd,
                        input logic [4:0] r1, input bit u1,
                        input logic [4:0] r2, input bit u2);
    ex_is_load_i = ld; ex_wreg_i = wr; ex_rd_addr_i = rd;
    id_rs1_addr_i = r1; id_rs1_read_i = u1;
    id_rs2_addr_i = r2; id_rs2_read_i = u2;
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic bit hazard();
    if (!(ex_is_load_i && ex_wreg_i) || ex_rd_addr_i == 5'd0) return 1'b0;
    return (id_rs1_read_i && id_rs1_addr_i == ex_rd_addr_i) ||
           (id_rs2_read_i && id_rs2_addr_i == ex_rd_addr_i);
  endfunction

  task automatic model_eval(output logic [11:0] e, output bit n_mem, output bit n_mc);
    bit mem_blocked;
    e = '0; n_mem = 0; n_mc = 0;
    // An unacked access holds the pipe either when it is a new request or
    // when it is an earlier miss that is still outstanding.
    mem_blocked = !mem_ack_i && (m_wait_mem || mem_req_i);
    if (rst) e = {5'b00000, 5'b11111, 2'b00};
    else if (m_wait_mc) begin
      if (!ex_mc_done_i) begin e = {5'b00111, 5'b01000, 2'b00}; n_mc = 1; end
    end else if (mem_blocked) begin
      e = {5'b01111, 5'b10000, 2'b00}; n_mem = 1;
    end else if (ex_mc_req_i && !ex_mc_done_i) begin
      e = {5'b00111, 5'b01000, 2'b01}; n_mc = 1;
    end else if (ex_branch_flag_i) e = {5'b00000, 5'b00110, 2'b10};
    else if (hazard()) e = {5'b00011, 5'b00100, 2'b00};
  endtask

  task automatic model_commit(input bit n_mem, input bit n_mc);
    if (rst) begin
      m_wait_mem = 0; m_wait_mc = 0; m_cnt = 0; m_to = 0;
    end else begin
      m_wait_mem = n_mem; m_wait_mc = n_mc;
      if (n_mem || n_mc) m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
      else m_cnt = 0;
      if (m_cnt == MAXC) m_to = 1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1; drive_ctl(1, 0, 1, 0, 1);
    set_lu(1, 1, 5'd3, 5'd3, 1, 5'd0, 0);
    #1;
    got = {stall_o, flush_o, pc_redirect_o, mc_start_o};
    exp_v = {5'b00000, 5'b11111, 2'b00};
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset_outputs: got %b expected %b", got, exp_v); end
    checks++;
    if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
    @(negedge clk);
    rst = 0; drive_ctl(0, 0, 0, 0, 0); set_lu(0, 0, 0, 0, 0, 0, 0);
    #1;
    got = {stall_o, flush_o, pc_redirect_o, mc_start_o};
    checks++;
    if (got !== 12'd0) begin errors++; $display("FAIL reset_release: got %b expected %b", got, 12'd0); end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_ctl(0, 0, 0, 0, 0);
      case (i)
        0: set_lu(1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        1: set_lu(0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        2: set_lu(1, 1, 5'd0, 5'd0, 1, 5'd0, 1);
        3: set_lu(1, 1, 5'd7, 5'd7, 0, 5'd7, 1);
        4: set_lu(1, 1, 5'd9, 5'd9, 0, 5'd9, 0);
        default: set_lu(1, 0, 5'd6, 5'd6, 1, 5'd6, 1);
      endcase
      exp_v = (i == 0 || i == 3) ? {5'b00011, 5'b00100, 2'b00} : 12'd0;
      #1;
      got = {stall_o, flush_o, pc_redirect_o, mc_start_o};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL load_use step %0d: got %b expected %b", i, got, exp_v); end
    end
  endtask

  task automatic test_branch_lu();
    @(negedge clk);
    set_lu(1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    drive_ctl(0, 0, 0, 0, 1);
    ex_pc_new_i = 64'h0000_0000_8000_0103;
    #1;
    got = {stall_o, flush_o, pc_redirect_o, mc_start_o};
    exp_v = {5'b00000, 5'b00110, 2'b10};
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL branch_lu: got %b expected %b", got, exp_v); end
    checks++;
    if (pc_redirect_addr_o !== 64'h0000_0000_8000_0102) begin
      errors++; $display("FAIL redirect_addr: got %h expected %h", pc_redirect_addr_o, 64'h8000_0102);
    end
    @(negedge clk);
    set_lu(0, 0, 0, 0, 0, 0, 0); drive_ctl(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (pc_redirect_o !== 1'b0) begin errors++; $display("FAIL redirect_one_cycle: got %b expected 0", pc_redirect_o); end
  endtask

  task automatic test_mem_miss();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      case (i)
        0: drive_ctl(1, 0, 1, 0, 1);      // miss wins over mc_req and branch
        1, 2: drive_ctl(1, 0, 0, 0, 0);
        3: drive_ctl(1, 1, 0, 0, 0);      // ack
        default: drive_ctl(0, 0, 0, 0, 0);
      endcase
      exp_v = (i < 3) ? {5'b01111, 5'b10000, 2'b00} : 12'd0;
      #1;
      got = {stall_o, flush_o, pc_redirect_o, mc_start_o};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL mem_miss step %0d: got %b expected %b", i, got, exp_v); end
    end
  endtask

  task automatic test_multicycle();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      case (i)
        0: drive_ctl(0, 0, 1, 0, 0);
        1, 2, 3: drive_ctl(1, 0, 1, 0, 0); // mem_req ignored during MC_WAIT
        4: drive_ctl(0, 0, 1, 1, 0);
        5: drive_ctl(0, 0, 0, 0, 0);
        default: drive_ctl(0, 0, 1, 1, 0); // done with request: no wait
      endcase
      if (i == 0) exp_v = {5'b00111, 5'b01000, 2'b01};
      else if (i < 4) exp_v = {5'b00111, 5'b01000, 2'b00};
      else exp_v = 12'd0;
      #1;
      got = {stall_o, flush_o, pc_redirect_o, mc_start_o};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL multicycle step %0d: got %b expected %b", i, got, exp_v); end
    end
  endtask

  task automatic test_mem_to_mc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      case (i)
        0: drive_ctl(1, 0, 0, 0, 0);
        1: drive_ctl(1, 1, 1, 0, 0);
        2: drive_ctl(0, 0, 1, 0, 0);
        3: drive_ctl(0, 0, 1, 1, 0);
        default: drive_ctl(0, 0, 0, 0, 0);
      endcase
      case (i)
        0: exp_v = {5'b01111, 5'b10000, 2'b00};
        1: exp_v = {5'b00111, 5'b01000, 2'b01};
        2: exp_v = {5'b00111, 5'b01000, 2'b00};
        default: exp_v = 12'd0;
      endcase
      #1;
      got = {stall_o, flush_o, pc_redirect_o, mc_start_o};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL mem_to_mc step %0d: got %b expected %b", i, got, exp_v); end
    end
  endtask

  task automatic test_watchdog();
    bit exp_to;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      drive_ctl(1, 0, 0, 0, 0);
      #1;
      exp_to = (n > MAXC);
      checks++;
      if (timeout_o !== exp_to || stall_o !== 5'b01111) begin
        errors++;
        $display("FAIL watchdog wait %0d: got timeout=%b stall=%b expected timeout=%b stall=01111",
                 n, timeout_o, stall_o, exp_to);
      end
    end
    @(negedge clk); drive_ctl(1, 1, 0, 0, 0);
    @(negedge clk); drive_ctl(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (timeout_o !== 1'b1 || stall_o !== 5'b00000) begin
      errors++; $display("FAIL watchdog_sticky: got timeout=%b stall=%b expected 1 00000", timeout_o, stall_o);
    end
    @(negedge clk); drive_ctl(1, 0, 0, 0, 0);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; drive_ctl(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (timeout_o !== 1'b0 || stall_o !== 5'b00000) begin
      errors++; $display("FAIL watchdog_reset: got timeout=%b stall=%b expected 0 00000", timeout_o, stall_o);
    end
  endtask

  task automatic test_random();
    bit n_mem, n_mc;
    logic [11:0] e;
    @(negedge clk); rst = 1;
    m_wait_mem = 0; m_wait_mc = 0; m_cnt = 0; m_to = 0;
    @(posedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      mem_req_i = ($urandom_range(0, 3) == 0);
      mem_ack_i = ($urandom_range(0, 9) < 3);
      ex_mc_req_i = ($urandom_range(0, 4) == 0);
      ex_mc_done_i = ($urandom_range(0, 9) < 2);
      ex_branch_flag_i = ($urandom_range(0, 5) == 0);
      ex_pc_new_i = {$urandom, $urandom};
      set_lu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      #1;
      model_eval(e, n_mem, n_mc);
      got = {stall_o, flush_o, pc_redirect_o, mc_start_o};
      checks++;
      if (got !== e || timeout_o !== m_to ||
          pc_redirect_addr_o !== {ex_pc_new_i[63:1], 1'b0}) begin
        errors++;
        $display("FAIL random cycle %0d: got ctl=%b to=%b addr=%h expected ctl=%b to=%b addr=%h",
                 c, got, timeout_o, pc_redirect_addr_o, e, m_to, {ex_pc_new_i[63:1], 1'b0});
      end
      @(posedge clk);
      model_commit(n_mem, n_mc);
    end
    @(negedge clk); rst = 0; drive_ctl(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_miss();
    test_multicycle();
    test_mem_to_mc();
    test_watchdog();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
